// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS bit positions and the transmit state encoding.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted only
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: a 16-byte register window on the data
// bus feeding a TX FIFO and a programmable-divisor serialiser.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int               FIFO_DEPTH  = 8,
  parameter logic [15:0]      DEFAULT_DIV = 16'd868
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] addr_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [3:0]       byteen,
  output logic [WIDTH-1:0] mem_data_out,
  output logic             o_tx,
  output logic             o_irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t     state;
  logic [15:0]   bauddiv;
  logic [15:0]   baud_cnt;
  logic [15:0]   baud_load;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          overflow;
  logic          hit;
  logic [1:0]    off;
  logic          wr_en;
  logic          rd_en;
  logic          tx_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          busy;
  logic          bit_end;
  logic          unused_bits;

  function automatic logic [15:0] div_load(input logic [15:0] div);
    return (div == 16'd0) ? 16'd0 : div - 16'd1;
  endfunction

  function automatic logic [3:0] sat_count(input logic [CW-1:0] c);
    if (int'(c) > 15) return 4'hF;
    return 4'(c);
  endfunction

  assign hit       = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
  assign off       = addr_in[3:2];
  assign wr_en     = hit && mem_write;
  assign rd_en     = hit && mem_read;
  assign tx_push   = wr_en && (off == REG_TXDATA) && byteen[0];
  assign busy      = (state != IDLE);
  assign bit_end   = (baud_cnt == 16'd0);
  assign baud_load = div_load(bauddiv);
  assign fifo_pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign unused_bits = ^{byteen[3:2], data_in[WIDTH-1:16], addr_in[1:0]};

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (fifo_pop),
    .din   (data_in[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Reads reflect current register state, so a simultaneous write is not yet visible.
  always_comb begin
    mem_data_out = '0;
    if (rd_en) begin
      case (off)
        REG_STATUS: begin
          mem_data_out[STAT_FULL]  = fifo_full;
          mem_data_out[STAT_EMPTY] = fifo_empty;
          mem_data_out[STAT_BUSY]  = busy;
          mem_data_out[STAT_OVF]   = overflow;
          mem_data_out[STAT_CNT_LSB +: 4] = sat_count(fifo_count);
        end
        REG_BAUDDIV: mem_data_out[15:0] = bauddiv;
        default:     mem_data_out = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bauddiv  <= DEFAULT_DIV;
      overflow <= 1'b0;
    end else begin
      if (wr_en && (off == REG_BAUDDIV)) begin
        if (byteen[0]) bauddiv[7:0]  <= data_in[7:0];
        if (byteen[1]) bauddiv[15:8] <= data_in[15:8];
      end
      if (tx_push && fifo_full && !fifo_pop)
        overflow <= 1'b1;
      else if (wr_en && (off == REG_STATUS) && byteen[0] && data_in[STAT_OVF])
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop)
      shift_reg <= fifo_dout;
    else if ((state == DATA) && bit_end && (bit_idx != 3'd7))
      shift_reg <= {1'b0, shift_reg[7:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      o_tx     <= 1'b1;
      o_irq    <= 1'b1;
    end else begin
      o_irq <= fifo_empty && !busy;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            state    <= START;
            baud_cnt <= baud_load;
            o_tx     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state    <= DATA;
            baud_cnt <= baud_load;
            bit_idx  <= 3'd0;
            o_tx     <= shift_reg[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= baud_load;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              o_tx  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (!fifo_empty) begin
              state    <= START;
              baud_cnt <= baud_load;
              o_tx     <= 1'b0;
            end else begin
              state <= IDLE;
              o_tx  <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          o_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register reads, frame timing, back-to-back
// frames, FIFO overflow, mid-frame divisor change and mid-frame reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE     = 32'h1000_0000;
  localparam logic [31:0] A_TX     = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_BAUD   = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr_in = '0;
  logic [31:0] data_in = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] mem_data_out;
  logic        o_tx;
  logic        o_irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
    string       name;
  } rd_vec_t;

  typedef struct {
    logic [15:0] div;
    logic [7:0]  data;
  } frame_vec_t;

  rd_vec_t    rd_tab [6];
  frame_vec_t fr_tab [4];

  always #5 clk = ~clk;

  mmio_uart_tx dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr_in      (addr_in),
    .data_in      (data_in),
    .byteen       (byteen),
    .mem_data_out (mem_data_out),
    .o_tx         (o_tx),
    .o_irq        (o_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    addr_in   = a;
    data_in   = d;
    byteen    = be;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    byteen    = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_in  = a;
    mem_read = 1'b1;
    #1;
    d        = mem_data_out;
    mem_read = 1'b0;
  endtask

  task automatic run_read_table(input string tag);
    logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus_read(rd_tab[i].addr, rd);
      check($sformatf("%s %s", tag, rd_tab[i].name), rd, rd_tab[i].exp);
    end
  endtask

  // Samples one frame starting at the next falling edge; start bit lasts d0 cycles, the rest dn.
  task automatic check_frame(input logic [7:0] b, input int d0, input int dn, input string tag);
    logic exp_bit;
    logic bit_ok;
    logic irq_ok;
    int   dur;
    irq_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dur     = (i == 0) ? d0 : dn;
      exp_bit = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
      bit_ok  = 1'b1;
      repeat (dur) begin
        @(negedge clk);
        if (o_tx !== exp_bit) bit_ok = 1'b0;
        if (o_irq !== 1'b0) irq_ok = 1'b0;
      end
      check($sformatf("%s bit%0d ok", tag, i), {31'b0, bit_ok}, 32'd1);
    end
    check($sformatf("%s irq low during frame", tag), {31'b0, irq_ok}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        stay_high;
    int          eff;

    rd_tab[0] = '{A_STATUS,      32'h0000_0002, "STATUS"};
    rd_tab[1] = '{A_BAUD,        32'h0000_0364, "BAUDDIV"};
    rd_tab[2] = '{A_TX,          32'h0000_0000, "TXDATA"};
    rd_tab[3] = '{BASE + 32'hC,  32'h0000_0000, "reserved"};
    rd_tab[4] = '{BASE + 32'h10, 32'h0000_0000, "outside+10"};
    rd_tab[5] = '{32'h0000_0004, 32'h0000_0000, "outside low"};

    fr_tab[0] = '{16'd4, 8'h55};
    fr_tab[1] = '{16'd1, 8'h81};
    fr_tab[2] = '{16'd0, 8'hC3};
    fr_tab[3] = '{16'd3, 8'h0F};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset o_tx", {31'b0, o_tx}, 32'd1);
    check("reset o_irq", {31'b0, o_irq}, 32'd1);
    run_read_table("reset");

    for (int i = 0; i < 4; i++) begin
      eff = (fr_tab[i].div == 16'd0) ? 1 : int'(fr_tab[i].div);
      bus_write(A_BAUD, {16'b0, fr_tab[i].div}, 4'b0011);
      bus_write(A_TX, {24'b0, fr_tab[i].data}, 4'b0001);
      check_frame(fr_tab[i].data, eff, eff, $sformatf("frame%0d", i));
      repeat (3) @(negedge clk);
      check($sformatf("frame%0d irq after", i), {31'b0, o_irq}, 32'd1);
    end

    // Per-byte enables on BAUDDIV (currently 3).
    bus_write(A_BAUD, 32'h0000_ABCD, 4'b0001);
    bus_read(A_BAUD, rd);
    check("baud low byte only", rd, 32'h0000_00CD);
    bus_write(A_BAUD, 32'h0000_1200, 4'b0010);
    bus_read(A_BAUD, rd);
    check("baud high byte only", rd, 32'h0000_12CD);

    // Simultaneous read and write returns the old value.
    @(negedge clk);
    addr_in   = A_BAUD;
    data_in   = 32'h0000_0002;
    byteen    = 4'b0011;
    mem_write = 1'b1;
    mem_read  = 1'b1;
    #1;
    check("read during write old", mem_data_out, 32'h0000_12CD);
    @(negedge clk);
    mem_write = 1'b0;
    byteen    = '0;
    #1;
    check("read after write new", mem_data_out, 32'h0000_0002);
    mem_read = 1'b0;

    // Back-to-back frames at divisor 2.
    bus_write(A_TX, 32'h0000_00A5, 4'b0001);
    fork
      begin
        check_frame(8'hA5, 2, 2, "b2b0");
        check_frame(8'h3C, 2, 2, "b2b1");
      end
      bus_write(A_TX, 32'h0000_003C, 4'b0001);
    join
    repeat (3) @(negedge clk);
    check("b2b irq after", {31'b0, o_irq}, 32'd1);

    // Divisor raised mid start bit: start keeps 4 cycles, later bits use 8.
    bus_write(A_BAUD, 32'h0000_0004, 4'b0011);
    bus_write(A_TX, 32'h0000_0096, 4'b0001);
    fork
      check_frame(8'h96, 4, 8, "midbaud");
      begin
        @(negedge clk);
        bus_write(A_BAUD, 32'h0000_0008, 4'b0011);
      end
    join
    repeat (3) @(negedge clk);

    // Overflow: one byte goes straight to the shifter, eight fill the FIFO, the tenth drops.
    bus_write(A_BAUD, 32'h0000_0064, 4'b0011);
    for (int i = 0; i < 10; i++) bus_write(A_TX, 32'h10 + i, 4'b0001);
    bus_read(A_STATUS, rd);
    check("overflow status", rd, 32'h0000_008D);
    bus_read(A_TX, rd);
    check("txdata reads zero", rd, 32'h0000_0000);
    bus_write(A_STATUS, 32'h0000_0008, 4'b0001);
    bus_read(A_STATUS, rd);
    check("overflow cleared", rd, 32'h0000_0085);

    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, rd);
    check("status after reset", rd, 32'h0000_0002);

    // Reset in the middle of a data bit with three bytes queued.
    bus_write(A_BAUD, 32'h0000_0004, 4'b0011);
    bus_write(A_TX, 32'h0000_0011, 4'b0001);
    bus_write(A_TX, 32'h0000_0022, 4'b0001);
    bus_write(A_TX, 32'h0000_0033, 4'b0001);
    bus_write(A_TX, 32'h0000_0044, 4'b0001);
    repeat (6) @(negedge clk);
    bus_read(A_STATUS, rd);
    check("queued before reset", rd, 32'h0000_0034);
    #1;
    reset = 1'b1;
    #1;
    check("async reset o_tx", {31'b0, o_tx}, 32'd1);
    check("async reset o_irq", {31'b0, o_irq}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus_read(A_STATUS, rd);
    check("status after mid reset", rd, 32'h0000_0002);
    stay_high = 1'b1;
    repeat (120) begin
      @(negedge clk);
      if (o_tx !== 1'b1) stay_high = 1'b0;
    end
    check("no frames after reset", {31'b0, stay_high}, 32'd1);
    run_read_table("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter that responds on the core's data memory bus: mem_read, mem_write, addr_in, data_in, byteen, mem_data_out.
- It decodes a 16-byte window and buffers bytes written by the core in a FIFO.
- It serialises each byte as 8N1 on o_tx at a programmable baud divisor.
- It sits beside memory_bus at top level; the top level ORs mem_data_out from both responders.

Parameters:
- WIDTH, 32, bus data/address width.
- BASE_ADDR, 32'h1000_0000, window base; must be 16-byte aligned.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd868, baud divisor after reset (clock cycles per bit).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- mem_read  in  1  bus read strobe.
- mem_write  in  1  bus write strobe.
- addr_in  in  WIDTH  byte address.
- data_in  in  WIDTH  write data.
- byteen  in  4  byte enables.
- mem_data_out  out  WIDTH  read data; 0 when not selected.
- o_tx  out  1  serial line; idles high.
- o_irq  out  1  high while FIFO empty and transmitter idle.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high, named reset. All state clears immediately on reset assertion.
- Reset values: o_tx=1, o_irq=1, mem_data_out=0, FIFO empty, FSM IDLE, BAUDDIV=DEFAULT_DIV, overflow flag=0.
- Select: hit = (addr_in[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]). Register offset is addr_in[3:2].
- Register map:
  - 0x0 TXDATA, write-only. Write with byteen[0]=1 pushes data_in[7:0]. Reads return 0.
  - 0x4 STATUS, read: bit0 full, bit1 empty, bit2 busy, bit3 overflow, bits[7:4] FIFO count (saturating field; FIFO_DEPTH ≤ 15 shown exactly). Write with data_in[3]=1 and byteen[0]=1 clears overflow.
  - 0x8 BAUDDIV, read/write, bits[15:0]. Writes honour byteen[1:0] per byte. Upper bits read 0.
  - 0xC reserved; reads 0, writes ignored.
- Reads are combinational, same cycle: mem_data_out = register value when hit && mem_read, else 0.
- Writes take effect at the rising edge where hit && mem_write.
- mem_read and mem_write together: both act; the read returns the pre-write value.
- FIFO push:
  - Accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set (sticky).
  - Count never exceeds FIFO_DEPTH; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: if FIFO non-empty at an edge, pop to the shift register, load the baud counter, enter START. o_tx=0 from that edge.
- A write at edge E0 to an empty FIFO with the FSM idle gives o_tx low from edge E1.
- Baud counter:
  - Loads eff_div-1, where eff_div = max(BAUDDIV,1).
  - Decrements each cycle; a bit ends when the counter is 0.
  - Each bit lasts exactly eff_div cycles.
  - BAUDDIV written mid-frame takes effect at the next counter reload; the current bit is not shortened.
- START: o_tx=0 for one bit time, then DATA.
- DATA: 8 bits, LSB first, o_tx=shift[0]. Shift right at each bit end. A 3-bit bit index stops after bit 7, then STOP.
- STOP: o_tx=1 for one bit time. At its end, if the FIFO is non-empty, pop and go directly to START (back-to-back, no idle gap); else go to IDLE.
- Frame length is 10*eff_div cycles.
- busy = (state != IDLE). o_irq = empty && !busy, registered.
- Reset mid-frame: o_tx returns high immediately and queued bytes are discarded.

Decomposition:
- uart_pkg holds:
  - register offset constants (TXDATA=2'd0, STATUS=2'd1, BAUDDIV=2'd2);
  - STATUS bit-index constants;
  - tx_state_t enum {IDLE, START, DATA, STOP}.
- Natural sub-module: sync_fifo (parameters WIDTH=8, DEPTH).
  - Inputs: push, pop, din. Outputs: dout, full, empty, count.
  - Same-cycle push+pop when full is legal.
- Top-level integration ORs mem_data_out with memory_bus output; that is outside this block.

Test Plan:
- Reset, read STATUS at 0x1000_0004 -> 0x0000_0002; read BAUDDIV -> 0x0000_0364; o_tx=1, o_irq=1.
- Write BAUDDIV=4, write TXDATA=0x55 -> o_tx low one cycle after the write edge. Then 4-cycle bits 1,0,1,0,1,0,1,0, then stop 1. Total 40 cycles, then o_irq=1.
- BAUDDIV=2, write 0xA5 and 0x3C back-to-back -> two contiguous 20-cycle frames. o_tx high only during the stop bit between them; busy stays 1 for 40 cycles.
- BAUDDIV=100, write 10 bytes rapidly:
  - first byte pops immediately, FIFO fills to 8;
  - the 10th write is dropped; STATUS reads 0x0000_008D (count 8, overflow, busy, full);
  - write STATUS data 0x8 -> overflow clears.
- BAUDDIV=0 -> each bit lasts 1 cycle, frame 10 cycles. Write BAUDDIV=8 mid-frame -> change applies from the next bit boundary.
- Assert reset mid-DATA with 3 bytes queued -> o_tx=1 immediately, STATUS=0x2 after release, no further frames. Read at 0x1000_0010 (outside window) -> mem_data_out=0.
